// File: rtl/regfile_sb_pkg.sv
// Shared widths and constants for the register file / scoreboard.
// REGFILE_BYPASS_EN (optional) turns on write-back to read forwarding.
package regfile_sb_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int REG_NUM = 32;
    localparam int PEND_W  = 2;

    localparam logic [DATA_W-1:0] ZeroWord   = '0;
    localparam logic [ADDR_W-1:0] NOPRegAddr = '0;
    localparam logic              Enable     = 1'b1;
    localparam logic              Disable    = 1'b0;

    // REGFILE_BYPASS_EN is consumed in regfile_sb.sv; leave undefined
    // for a plain register file with no same-cycle forwarding.

endpackage

// File: rtl/regfile_pend_cnt.sv
// One per-register pending-write counter, up/down, saturating.
// Ports: clk, rst (async active-low), inc, dec, cnt.
module regfile_pend_cnt
    import regfile_sb_pkg::*;
#(
    parameter int W = PEND_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Retiring a write nobody issued means decode and WB disagree.
    always_ff @(posedge clk) begin
        if (rst && dec && !inc) begin
            assert (cnt != '0);
        end
    end
`endif

endmodule

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard and decode stall request.
// Ports: clk, rst (async active-low), re1/raddr1/rdata1, re2/raddr2/rdata2,
//   issue_we/issue_waddr (decode issue), we/waddr/wdata (write-back),
//   stallreq. Optional macro REGFILE_BYPASS_EN forwards wdata to reads.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W  = regfile_sb_pkg::DATA_W,
    parameter int ADDR_W  = regfile_sb_pkg::ADDR_W,
    parameter int REG_NUM = regfile_sb_pkg::REG_NUM,
    parameter int PEND_W  = regfile_sb_pkg::PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_waddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stallreq
);

    localparam logic [PEND_W-1:0] PendMax = '1;
    localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);
    localparam logic [ADDR_W-1:0] Zero    = '0;

    logic [DATA_W-1:0]              regs [REG_NUM];
    logic [REG_NUM-1:0][PEND_W-1:0] pend;

    logic haz1, haz2, ovf;
    logic byp1, byp2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (we == Enable && waddr != Zero) begin
            regs[waddr] <= wdata;
        end
    end

    assign pend[0] = '0;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
        regfile_pend_cnt #(.W(PEND_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (issue_we && issue_waddr == ADDR_W'(r) && !stallreq),
            .dec (we && waddr == ADDR_W'(r)),
            .cnt (pend[r])
        );
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1 = we && waddr == raddr1 && waddr != Zero;
    assign byp2 = we && waddr == raddr2 && waddr != Zero;
`else
    assign byp1 = Disable;
    assign byp2 = Disable;
`endif

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rst && re1 && raddr1 != Zero) begin
            rdata1 = byp1 ? wdata : regs[raddr1];
        end
        if (rst && re2 && raddr2 != Zero) begin
            rdata2 = byp2 ? wdata : regs[raddr2];
        end
    end

    // A read is safe once the only outstanding write is retiring now
    // and its data is being forwarded.
    always_comb begin
        haz1 = re1 && raddr1 != Zero && pend[raddr1] != '0
            && !(byp1 && pend[raddr1] == PendOne);
        haz2 = re2 && raddr2 != Zero && pend[raddr2] != '0
            && !(byp2 && pend[raddr2] == PendOne);
        ovf  = issue_we && issue_waddr != Zero
            && pend[issue_waddr] == PendMax;
    end

    assign stallreq = rst && (haz1 || haz2 || ovf);

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then random traffic
// against an array-based reference model (honours REGFILE_BYPASS_EN).
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        re1 = 1'b0, re2 = 1'b0;
    logic [4:0]  raddr1 = '0, raddr2 = '0;
    logic [31:0] rdata1, rdata2;
    logic        issue_we = 1'b0;
    logic [4:0]  issue_waddr = '0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        stallreq;

    int checks = 0;
    int errors = 0;

    logic [31:0] mreg [32];
    int          mpend [32];

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk         (clk),
        .rst         (rst),
        .re1         (re1),
        .raddr1      (raddr1),
        .rdata1      (rdata1),
        .re2         (re2),
        .raddr2      (raddr2),
        .rdata2      (rdata2),
        .issue_we    (issue_we),
        .issue_waddr (issue_waddr),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .stallreq    (stallreq)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic re, input logic [4:0] a);
        if (!re || a == 0) return 32'h0;
        if (BYP && we && waddr == a) return wdata;
        return mreg[a];
    endfunction

    function automatic bit m_haz(input logic re, input logic [4:0] a);
        if (!re || a == 0 || mpend[a] == 0) return 1'b0;
        if (BYP && we && waddr == a && mpend[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        bit ovf;
        ovf = issue_we && issue_waddr != 0 && mpend[issue_waddr] == 3;
        return m_haz(re1, raddr1) || m_haz(re2, raddr2) || ovf;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            mreg[i]  = '0;
            mpend[i] = 0;
        end
    endtask

    // Inputs are driven at the falling edge; one clock is checked and
    // the model advanced with the values that were present at the edge.
    task automatic cycle(input string tag);
        bit st;
        #1;
        st = m_stall();
        chk({tag, ".rd1"}, rdata1, m_read(re1, raddr1));
        chk({tag, ".rd2"}, rdata2, m_read(re2, raddr2));
        chk({tag, ".stall"}, {31'b0, stallreq}, {31'b0, st});
        @(posedge clk);
        if (issue_we && issue_waddr != 0 && !st) mpend[issue_waddr]++;
        if (we && waddr != 0) begin
            mreg[waddr] = wdata;
            if (mpend[waddr] > 0) mpend[waddr]--;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        re1 = 0; re2 = 0; issue_we = 0; we = 0;
        raddr1 = 0; raddr2 = 0; issue_waddr = 0; waddr = 0; wdata = 0;
    endtask

    task automatic issue(input logic [4:0] r, input string tag);
        idle();
        issue_we = 1; issue_waddr = r;
        cycle(tag);
    endtask

    task automatic retire(input logic [4:0] r, input logic [31:0] d,
                          input string tag);
        idle();
        we = 1; waddr = r; wdata = d;
        cycle(tag);
    endtask

    initial begin
        m_clear();
        // Held in reset with live requests: everything must read as 0.
        re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 7;
        issue_we = 1; issue_waddr = 4;
        #2;
        chk("rst.rd1", rdata1, 32'h0);
        chk("rst.rd2", rdata2, 32'h0);
        chk("rst.stall", {31'b0, stallreq}, 32'h0);
        idle();
        @(negedge clk);
        rst = 1;
        @(negedge clk);

        // Write then read back; $0 stays zero.
        issue(5'd3, "wr.iss");
        retire(5'd3, 32'h1234_5678, "wr.wb");
        idle();
        re1 = 1; raddr1 = 3;
        #1 chk("wr.rd3", rdata1, 32'h1234_5678);
        cycle("wr.rd");
        retire(5'd0, 32'hFFFF_FFFF, "wr.wb0");
        idle();
        re1 = 1; raddr1 = 0;
        #1 chk("wr.rd0", rdata1, 32'h0);
        cycle("wr.rd0c");

        // Same-cycle write and read of $7.
        issue(5'd7, "byp.iss");
        idle();
        we = 1; waddr = 7; wdata = 32'h0000_A5A5; re2 = 1; raddr2 = 7;
        #1 chk("byp.same", rdata2, BYP ? 32'h0000_A5A5 : 32'h0);
        cycle("byp.wb");
        idle();
        re2 = 1; raddr2 = 7;
        #1 chk("byp.next", rdata2, 32'h0000_A5A5);
        cycle("byp.rd");

        // RAW hazard on $9 until its write-back.
        issue(5'd9, "sb.iss");
        idle();
        re1 = 1; raddr1 = 9;
        #1 chk("sb.wait", {31'b0, stallreq}, 32'h1);
        cycle("sb.w1");
        cycle("sb.w2");
        we = 1; waddr = 9; wdata = 32'hCAFE_0009;
        #1 chk("sb.ret", {31'b0, stallreq}, BYP ? 32'h0 : 32'h1);
        cycle("sb.retc");
        we = 0;
        #1 chk("sb.after", {31'b0, stallreq}, 32'h0);
        cycle("sb.afterc");

        // Pending-count overflow on $4, then issue+retire together.
        issue(5'd4, "ov.i1");
        issue(5'd4, "ov.i2");
        issue(5'd4, "ov.i3");
        idle();
        issue_we = 1; issue_waddr = 4;
        #1 chk("ov.full", {31'b0, stallreq}, 32'h1);
        cycle("ov.i4");
        issue(5'd4, "ov.i5");
        retire(5'd4, 32'h44, "ov.r1");
        idle();
        issue_we = 1; issue_waddr = 4; we = 1; waddr = 4; wdata = 32'h45;
        #1 chk("ov.both", {31'b0, stallreq}, 32'h0);
        cycle("ov.bothc");
        issue(5'd4, "ov.i6");
        idle();
        issue_we = 1; issue_waddr = 4;
        #1 chk("ov.refull", {31'b0, stallreq}, 32'h1);
        cycle("ov.i7");
        retire(5'd4, 32'h46, "ov.r2");
        retire(5'd4, 32'h47, "ov.r3");
        retire(5'd4, 32'h48, "ov.r4");

        // Asynchronous reset mid-cycle with pend[5] = 2.
        issue(5'd5, "ar.i1");
        issue(5'd5, "ar.i2");
        idle();
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 3;
        #1 chk("ar.pre", {31'b0, stallreq}, 32'h1);
        rst = 0;
        #1;
        chk("ar.rd1", rdata1, 32'h0);
        chk("ar.rd2", rdata2, 32'h0);
        chk("ar.stall", {31'b0, stallreq}, 32'h0);
        m_clear();
        @(negedge clk);
        rst = 1;
        idle();
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 3;
        #1;
        chk("ar.post5", rdata1, 32'h0);
        chk("ar.post3", rdata2, 32'h0);
        chk("ar.poststall", {31'b0, stallreq}, 32'h0);
        cycle("ar.postc");

        // Random traffic on a small register window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] r;
            idle();
            re1 = 1'($urandom_range(0, 1));
            re2 = 1'($urandom_range(0, 1));
            raddr1 = 5'($urandom_range(0, 7));
            raddr2 = 5'($urandom_range(0, 7));
            issue_we = 1'($urandom_range(0, 1));
            issue_waddr = 5'($urandom_range(0, 7));
            r = 5'($urandom_range(0, 7));
            if (r != 0 && mpend[r] > 0 && $urandom_range(0, 3) != 0) begin
                we = 1; waddr = r;
            end else if ($urandom_range(0, 7) == 0) begin
                we = 1; waddr = 0;
            end
            wdata = $urandom;
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
